// File: rtl/muldiv_sequencer.sv
// RV32M execution engine: single-cycle registered multiplier and a 32-step
// restoring divider, sequenced by a small FSM that stalls EX while busy.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   rem_q;
    logic [CW-1:0]   cnt_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            special_q;
    logic [XLEN-1:0] spec_res_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            in_is_mul;
    logic            in_signed;
    logic            in_dbz;
    logic            in_ovf;
    logic [XLEN-1:0] in_abs_a;
    logic [XLEN-1:0] in_abs_b;
    logic [XLEN-1:0] in_spec_res;

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign in_is_mul = !op[2];
    assign in_signed = !op[0];
    assign in_dbz    = (rs2 == '0);
    assign in_ovf    = in_signed && (rs1 == INT_MIN) && (rs2 == '1);
    assign in_abs_a  = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign in_abs_b  = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    // op[1] distinguishes REM/REMU from DIV/DIVU
    assign in_spec_res = op[1] ? (in_dbz ? rs1 : '0)
                               : (in_dbz ? '1 : INT_MIN);

    // Multiplier: operands extended to XLEN+1 bits so one signed multiply covers all four forms
    logic signed [XLEN:0]     mul_a;
    logic signed [XLEN:0]     mul_b;
    logic signed [2*XLEN+1:0] product;
    logic [XLEN-1:0]          mul_res;

    assign mul_a   = {(op_q[1:0] != 2'b11) & a_q[XLEN-1], a_q};
    assign mul_b   = {!op_q[1] & b_q[XLEN-1], b_q};
    assign product = mul_a * mul_b;
    assign mul_res = (op_q[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

    logic [XLEN:0]   div_shift;
    logic            div_ge;
    logic [XLEN:0]   div_diff;
    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] fix_res;

    assign div_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, dvs_q});
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign quo_fin   = neg_quo_q ? -quo_q : quo_q;
    assign rem_fin   = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    assign fix_res   = special_q ? spec_res_q : (op_q[1] ? rem_fin : quo_fin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (in_is_mul)                state_nxt = ST_MUL;
                    else if (in_dbz || in_ovf)    state_nxt = ST_FIX;
                    else                          state_nxt = ST_DIV;
                end
            end
            ST_MUL:  state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DIV: begin
                if (flush)                         state_nxt = ST_IDLE;
                else if (cnt_q == CW'(XLEN - 1))   state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dvs_q      <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            if (accept) begin
                op_q       <= op;
                a_q        <= rs1;
                b_q        <= rs2;
                dvs_q      <= in_abs_b;
                quo_q      <= in_abs_a;
                rem_q      <= '0;
                cnt_q      <= '0;
                neg_quo_q  <= in_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
                neg_rem_q  <= in_signed && rs1[XLEN-1];
                special_q  <= in_dbz || in_ovf;
                spec_res_q <= in_spec_res;
            end else if (state == ST_DIV) begin
                rem_q <= div_ge ? div_diff : div_shift;
                quo_q <= {quo_q[XLEN-2:0], div_ge};
                cnt_q <= cnt_q + CW'(1);
            end
            if (!flush) begin
                if (state == ST_MUL)      result_q <= mul_res;
                else if (state == ST_FIX) result_q <= fix_res;
            end
        end
    end

    assign busy   = (state == ST_MUL) || (state == ST_DIV) || (state == ST_FIX);
    assign done   = (state == ST_DONE);
    assign result = result_q;
    assign stall  = busy || (start && (state == ST_IDLE) && !flush);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, results, stall/done timing,
// flush and asynchronous reset behaviour against hand-computed values.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_res;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one op with start held until done; leaves start high afterwards when keep is set.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit keep);
        int  n;
        bit  stall_ok;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        #1;
        check({tag, "_stall_acc"}, 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        n = 1;
        stall_ok = 1'b1;
        while (!done && n < 100) begin
            if (!stall) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_stall_inflight"}, 32'(stall_ok), 32'd1);
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        last_res = exp_res;
        if (!keep) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'b000;
        rs1   = '0;
        rs2   = '0;
        last_res = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul",    3'b000, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 2, 1'b0);
        run_op("mulh",   3'b001, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 2, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'h2, 32'h00000001, 2, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 2, 1'b0);

        run_op("div",  3'b100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 34, 1'b0);
        run_op("rem",  3'b110, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 34, 1'b0);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);
        run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b1);
        // start still high: DONE -> IDLE, and the next op is taken on the following edge
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_stall", 32'(stall), 32'd1);

        run_op("divu_dbz", 3'b101, 32'h1234, 32'h0, 32'hFFFFFFFF, 2, 1'b0);
        run_op("rem_dbz",  3'b110, 32'h1234, 32'h0, 32'h00001234, 2, 1'b0);
        run_op("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
        run_op("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);
        run_op("mul_pre",  3'b000, 32'd6, 32'd7, 32'd42, 2, 1'b0);

        // flush at DIV count=10
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        rs1   = 32'd1000;
        rs2   = 32'd3;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        check("flush_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_result", result, last_res);
        @(negedge clk);
        start = 1'b1;
        #1;
        check("flush_idle_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("flush_idle_noacc", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        run_op("post_flush", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b0);

        // asynchronous reset mid-DIV
        @(negedge clk);
        start = 1'b1;
        op    = 3'b101;
        rs1   = 32'd500;
        rs2   = 32'd9;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 3'b101, 32'd500, 32'd9, 32'd55, 34, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle execution engine for RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), driven by the decoder's M-extension ops.
- Sits beside the ALU in EX and owns the iterative divider and the registered multiplier.
- Raises a pipeline stall while an operation is in flight and presents the result with a one-cycle done strobe.

Parameters:
XLEN, 32, operand/result width; only 32 is supported; the divider counter is sized by $clog2(XLEN)+1.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  EX holds an M-extension instruction; level, held until done
op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  operand A (dividend / multiplicand)
rs2  input  XLEN  operand B (divisor / multiplier)
flush  input  1  abort the in-flight operation (branch/trap kill)
busy  output  1  operation in flight (states MUL, DIV, FIX)
done  output  1  one-cycle strobe; result valid this cycle
result  output  XLEN  final result, held until the next accepted op
stall  output  1  combinational: busy | (start & state==IDLE & ~flush)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - Counter, remainder, quotient and operand registers all cleared.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- Accept: in IDLE with start=1 and flush=0, latch op, rs1 and rs2 on the rising edge.
  - Multiply op -> MUL.
  - Div/rem by zero (rs2==0) or signed overflow (op DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) -> FIX with the special result preselected.
  - All other divides -> DIV with count=0.
- MUL (1 cycle):
  - 64-bit product of 33-bit extended operands. rs1 is sign-extended for MUL/MULH/MULHSU; rs2 is sign-extended for MUL/MULH only.
  - MUL selects bits [31:0]; the others select [63:32].
  - MUL -> DONE.
- DIV (32 cycles):
  - Restoring radix-2 division on absolute values for DIV/REM, raw values for DIVU/REMU.
  - One quotient bit per cycle, MSB first. The 33-bit partial remainder is shifted left, the divisor is trial-subtracted, and the remainder is kept when the difference is non-negative.
  - Stay in DIV until count==31, then -> FIX.
- FIX (1 cycle):
  - Apply signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Special cases: div-by-zero gives quotient 0xFFFFFFFF and remainder rs1; overflow gives quotient 0x80000000 and remainder 0.
  - FIX -> DONE.
- DONE (1 cycle):
  - result is registered on entry to DONE; done=1 and busy=0.
  - stall=0 so the pipeline advances this cycle.
  - start is ignored in DONE (it is still the same instruction). DONE -> IDLE unconditionally.
- Latency, from the accepting edge to the edge that raises done:
  - MUL ops: 2 edges (IDLE->MUL->DONE).
  - Special-case divides: 2 edges (IDLE->FIX->DONE).
  - Normal divides: 34 edges (IDLE->DIV x32->FIX->DONE).
- Back-to-back ops: a new op is accepted at the earliest on the edge after DONE, i.e. in IDLE.
- Flush:
  - In MUL/DIV/FIX: go to IDLE on the next edge, with no done strobe and result unchanged.
  - Flush in IDLE suppresses acceptance.
  - Flush in DONE has no effect (done is already asserted).
- Operands are sampled only at accept; changes on rs1/rs2/op while busy are ignored.
- Reset asserted mid-operation: return to IDLE immediately, with all outputs at their reset values.

Test Plan:
- MUL rs1=0xFFFFFFFF, rs2=0x00000002 -> done 2 edges after accept, result 0xFFFFFFFE; repeat with MULH -> 0xFFFFFFFF, MULHU -> 0x00000001, MULHSU -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> done after exactly 34 edges, result 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU/REM by zero with rs1=0x1234 -> DIVU result 0xFFFFFFFF, REM result 0x1234, each in 2 edges; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM of the same -> 0.
- Start held high across the whole op -> stall high from the accept cycle through FIX, low in the DONE cycle; done high exactly one cycle; a second start accepted on the edge after DONE.
- Flush at DIV count=10 -> IDLE next edge, no done, result retains the prior value; a new start is then accepted normally.
- rst_n pulsed low mid-DIV (asynchronous, between edges) -> busy, done and result go to 0 immediately; stall=0 while start=0.
